npu_cube_add_seq: RTL
=====================

# npu_cube_add_seq

Iterative adder sequencer for the NPU cube adder's half-adder array. Accepts one operand pair per transaction over a valid/ready handshake. It drives the external `bitwidth`-wide half-adder array (per-bit `sum`/`carry`) repeatedly, feeding sum back as A and left-shifted carry back as B until no carry remains. It returns the modular sum, an overflow flag and the iteration count over a second valid/ready handshake. It sits between the cube accumulate scheduler and the half-adder array instance.

## Interface
- `bitwidth`, 8, operand/result width; legal range ≥ 2.
- `ITW` (localparam) = `$clog2(bitwidth+1)`; width of the iteration counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `in_a` in `bitwidth`: operand A.
- `in_b` in `bitwidth`: operand B.
- `ha_a` out `bitwidth`: to half-adder array input A.
- `ha_b` out `bitwidth`: to half-adder array input B.
- `ha_sum` in `bitwidth`: from array, `ha_a ^ ha_b`.
- `ha_carry` in `bitwidth`: from array, `ha_a & ha_b`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_sum` out `bitwidth`: `(in_a + in_b) mod 2^bitwidth`.
- `out_ovf` out 1: carry out of the MSB occurred (unsigned overflow).
- `out_iter` out `ITW`: number of RUN cycles used, 1..`bitwidth`.
- `busy` out 1: high in RUN.

## Operation
- Registers: `state`, `op_a`, `op_b`, `ovf`, `iter`.
- States: IDLE, RUN, DONE.
- Handshake: `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- Accept: `in_valid & in_ready` at an edge sets `op_a<=in_a`, `op_b<=in_b`, `ovf<=0`, `iter<=0`, and moves the state to RUN.
  - Accept occurs from IDLE, or from DONE in the same edge the result is consumed.
  - B=0 is not special-cased; it completes in 1 iteration.
- RUN, every cycle:
  - `op_a<=ha_sum`.
  - `op_b<={ha_carry[bitwidth-2:0],1'b0}`.
  - `ovf<=ovf|ha_carry[bitwidth-1]`.
  - `iter<=iter+1`.
  - When `ha_carry[bitwidth-2:0]==0`, go to DONE; otherwise stay in RUN.
- RUN is guaranteed to terminate within `bitwidth` cycles, because every carry bit shifts left once per cycle. There is no timeout logic.
- DONE:
  - `out_valid=1`; `out_sum=op_a`, `out_ovf=ovf`, `out_iter=iter` are held stable until consumed.
  - If `out_ready & in_valid`: load the new pair and go to RUN.
  - Else if `out_ready`: go to IDLE.
  - Else: stay in DONE.
- `ha_a=op_a` and `ha_b=op_b` only in RUN. Both are forced to 0 in IDLE and DONE (array quiescent).
- `out_valid=(state==DONE)`.
- `busy=(state==RUN)`.
- Inputs `in_a`/`in_b` are sampled only at accept; later changes are ignored.

## Timing
- Reset values:
  - state IDLE, all registers 0.
  - `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_ovf=0`, `out_iter=0`, `ha_a=0`, `ha_b=0`, `busy=0`.
- Array path is combinational (`ha_a`/`ha_b` → array → `ha_sum`/`ha_carry` → registers) within one cycle.
- Latency: for accept at edge T and k = required iterations, RUN covers cycles T+1..T+k and `out_valid` rises after edge T+k.
  - Accept-to-result = k+1 edges; worst case `bitwidth+1`.
- Throughput: with `out_ready` held high and `in_valid` continuous, there is no IDLE bubble. Transactions run back-to-back at k+1 cycles each.
- `out_ready` low in DONE: hold indefinitely; outputs must not change and `in_ready=0`.
- `rst` asserted in any state, including mid-RUN or in DONE with an unconsumed result:
  - Immediate return to the reset values; the in-flight result is discarded.
  - Normal accept resumes on the first edge after deassertion.
- `out_ready` asserted in IDLE or RUN has no effect.

## Test plan
- `bitwidth`=8, 3+5 → `out_sum`=0x08, `out_ovf`=0, `out_iter`=4; `out_valid` rises 5 edges after accept; `ha_a`/`ha_b` sequence (3,5), (6,2), (4,4), (0,8).
- 0xFF+0x01 → `out_sum`=0x00, `out_ovf`=1, `out_iter`=8 (worst case, 9-edge latency).
- 0x12+0x00 → `out_sum`=0x12, `out_ovf`=0, `out_iter`=1; `ha_a`/`ha_b`=0 before and after RUN.
- Backpressure: result 0x08 with `out_ready` low for 5 cycles → `out_valid` and outputs stable, `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 (0x80+0x80) → same-edge consume+accept, then `out_sum`=0x00, `out_ovf`=1, `out_iter`=1.
- `rst` pulsed during RUN cycle 2 of 0xFF+0x01 → all outputs at reset values immediately; next accept of 1+1 yields 0x02, `out_iter`=2, `out_ovf`=0.
- `bitwidth`=16, 10k random pairs with random `in_valid`/`out_ready` → `out_sum`/`out_ovf` match `{ovf,sum}=a+b`; `out_iter` ≤ 16; no lost or duplicated transactions.

Source files
------------

// File: rtl/npu_cube_add_seq.sv
// Iterative adder sequencer: drives an external half-adder array, feeding sum back as A and
// shifted carry back as B until the carry dies out. Returns sum, overflow and iteration count.
module npu_cube_add_seq #(
    parameter int bitwidth = 8,
    localparam int ITW = $clog2(bitwidth + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bitwidth-1:0] in_a,
    input  logic [bitwidth-1:0] in_b,
    output logic [bitwidth-1:0] ha_a,
    output logic [bitwidth-1:0] ha_b,
    input  logic [bitwidth-1:0] ha_sum,
    input  logic [bitwidth-1:0] ha_carry,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bitwidth-1:0] out_sum,
    output logic                out_ovf,
    output logic [ITW-1:0]      out_iter,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [bitwidth-1:0] op_a;
    logic [bitwidth-1:0] op_b;
    logic                ovf;
    logic [ITW-1:0]      iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            ovf   <= 1'b0;
            iter  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_a;
                        op_b  <= in_b;
                        ovf   <= 1'b0;
                        iter  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a <= ha_sum;
                    op_b <= {ha_carry[bitwidth-2:0], 1'b0};
                    ovf  <= ovf | ha_carry[bitwidth-1];
                    iter <= iter + ITW'(1);
                    // A carry out of the MSB is absorbed into ovf and cannot keep RUN alive
                    if (ha_carry[bitwidth-2:0] == '0)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready && in_valid) begin
                        op_a  <= in_a;
                        op_b  <= in_b;
                        ovf   <= 1'b0;
                        iter  <= '0;
                        state <= RUN;
                    end else if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    // Array inputs held at zero outside RUN so the array stays quiescent
    assign ha_a      = (state == RUN) ? op_a : '0;
    assign ha_b      = (state == RUN) ? op_b : '0;
    assign out_sum   = op_a;
    assign out_ovf   = ovf;
    assign out_iter  = iter;

endmodule
